// File: rtl/pixel_ctrl_gen.sv
// pixel_ctrl_gen -- pixel-stream timing generator.
//
// Walks a frame of (H_ACTIVE+H_BLANK) x (V_ACTIVE+V_BLANK) slots, one slot per
// cycle with valid_in=1, and emits the pixel control bus for each slot one
// cycle later. Runs continuously, or stops in IDLE after each frame in
// one-shot mode.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   valid_in    advance enable; position steps only when 1
//   one_shot    0 = continuous frames, 1 = stop after each frame
//   start       one-cycle pulse that leaves IDLE
//   hStart/hEnd first/last active pixel of an active line
//   vStart/vEnd first/last active pixel of the frame
//   valid       active pixel qualifier
//   hcount/vcount position of the emitted slot
//   frame_done  pulse on the last slot of the total frame (incl. blanking)
//   busy        1 while slots are being emitted in RUN
//   frame_cnt   (only with PIXEL_CTRL_FRAME_CNT_EN) 16-bit completed-frame count
//
// Optional feature macro: PIXEL_CTRL_FRAME_CNT_EN
module pixel_ctrl_gen #(
  parameter int H_ACTIVE = 16,
  parameter int V_ACTIVE = 12,
  parameter int H_BLANK  = 4,
  parameter int V_BLANK  = 2,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  input  logic          one_shot,
  input  logic          start,
  output logic          hStart,
  output logic          hEnd,
  output logic          vStart,
  output logic          vEnd,
  output logic          valid,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          frame_done,
`ifdef PIXEL_CTRL_FRAME_CNT_EN
  output logic [15:0]   frame_cnt,
`endif
  output logic          busy
);

  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_AEND = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_AEND = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE + H_BLANK - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_ACTIVE + V_BLANK - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] h_reg, h_next;
  logic [CW-1:0] v_reg, v_next;
  // Auto-run is only granted once after reset; later IDLE periods need start.
  logic          auto_reg, auto_next;
  logic          emit;

  // Decode of the slot currently addressed by the counters.
  logic act_d, hs_d, he_d, vs_d, ve_d, fd_d;

  always_comb begin
    act_d = (h_reg < H_ACT) && (v_reg < V_ACT);
    hs_d  = act_d && (h_reg == '0);
    he_d  = act_d && (h_reg == H_AEND);
    vs_d  = hs_d && (v_reg == '0);
    ve_d  = he_d && (v_reg == V_AEND);
    fd_d  = (h_reg == H_LAST) && (v_reg == V_LAST);
  end

  always_comb begin
    state_next = state_reg;
    h_next     = h_reg;
    v_next     = v_reg;
    auto_next  = auto_reg;
    emit       = 1'b0;
    case (state_reg)
      IDLE: begin
        h_next = '0;
        v_next = '0;
        if (start || (auto_reg && !one_shot)) begin
          state_next = RUN;
          auto_next  = 1'b0;
        end
      end
      RUN: begin
        // start is ignored here, so a start coinciding with the final-slot
        // exit is simply dropped.
        if (valid_in) begin
          emit = 1'b1;
          if (h_reg == H_LAST) begin
            h_next = '0;
            if (v_reg == V_LAST) begin
              v_next = '0;
              if (one_shot) state_next = IDLE;
            end else begin
              v_next = v_reg + CW'(1);
            end
          end else begin
            h_next = h_reg + CW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      h_reg     <= '0;
      v_reg     <= '0;
      auto_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      h_reg     <= h_next;
      v_reg     <= v_next;
      auto_reg  <= auto_next;
    end
  end

  // Registered output stage: one cycle behind the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hStart     <= 1'b0;
      hEnd       <= 1'b0;
      vStart     <= 1'b0;
      vEnd       <= 1'b0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      hcount     <= '0;
      vcount     <= '0;
      busy       <= 1'b0;
    end else begin
      // busy tracks the emitted slots, so it falls the cycle after frame_done.
      busy       <= (state_reg == RUN);
      hStart     <= emit && hs_d;
      hEnd       <= emit && he_d;
      vStart     <= emit && vs_d;
      vEnd       <= emit && ve_d;
      valid      <= emit && act_d;
      frame_done <= emit && fd_d;
      if (emit) begin
        hcount <= h_reg;
        vcount <= v_reg;
      end else if (state_reg == IDLE) begin
        hcount <= '0;
        vcount <= '0;
      end
    end
  end

`ifdef PIXEL_CTRL_FRAME_CNT_EN
  // Increments on the same edge that raises frame_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= 16'd0;
    end else if (emit && fd_d) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_ctrl_gen.sv
// Directed bench for pixel_ctrl_gen: a default-geometry instance and a
// zero-blanking 4x3 instance share the same stimulus.
module tb_pixel_ctrl_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, valid_in = 1'b0, one_shot = 1'b0, start = 1'b0;

  logic hs, he, vs, ve, vld, fd, busy;
  logic [11:0] hc, vc;
  logic hs2, he2, vs2, ve2, vld2, fd2, busy2;
  logic [11:0] hc2, vc2;
`ifdef PIXEL_CTRL_FRAME_CNT_EN
  logic [15:0] fc, fc2;
`endif

  int total = 0;
  int bad   = 0;

  pixel_ctrl_gen dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .one_shot(one_shot), .start(start),
    .hStart(hs), .hEnd(he), .vStart(vs), .vEnd(ve), .valid(vld),
    .hcount(hc), .vcount(vc), .frame_done(fd),
`ifdef PIXEL_CTRL_FRAME_CNT_EN
    .frame_cnt(fc),
`endif
    .busy(busy)
  );

  pixel_ctrl_gen #(.H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(0), .V_BLANK(0), .CW(12)) dut2 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .one_shot(one_shot), .start(start),
    .hStart(hs2), .hEnd(he2), .vStart(vs2), .vEnd(ve2), .valid(vld2),
    .hcount(hc2), .vcount(vc2), .frame_done(fd2),
`ifdef PIXEL_CTRL_FRAME_CNT_EN
    .frame_cnt(fc2),
`endif
    .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {valid,hStart,hEnd,vStart,vEnd,frame_done} for slot (h,v).
  function automatic logic [5:0] exp_ctl(input int h, input int v, input int ha,
                                         input int va, input int ht, input int vt);
    logic a, s, e;
    a = (h < ha) && (v < va);
    s = a && (h == 0);
    e = a && (h == ha - 1);
    return {a, s, e, s && (v == 0), e && (v == va - 1), (h == ht - 1) && (v == vt - 1)};
  endfunction

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b1; one_shot = 1'b0; start = 1'b0;
    repeat (3) tick();
    total++;
    if ({hs, he, vs, ve, vld, fd, busy} !== 7'b0 || hc !== 12'd0 || vc !== 12'd0) begin
      bad++;
      $display("FAIL reset_dut1: got ctl=%b hc=%0d vc=%0d, want all 0",
               {hs, he, vs, ve, vld, fd, busy}, hc, vc);
    end
    total++;
    if ({hs2, he2, vs2, ve2, vld2, fd2, busy2} !== 7'b0 || hc2 !== 12'd0 || vc2 !== 12'd0) begin
      bad++;
      $display("FAIL reset_dut2: got ctl=%b hc=%0d vc=%0d, want all 0",
               {hs2, he2, vs2, ve2, vld2, fd2, busy2}, hc2, vc2);
    end
  endtask

  task automatic test_continuous();
    int fd_first, fd_second, ve_k, he_n;
    fd_first = -1; fd_second = -1; ve_k = -1; he_n = 0;
    reset = 1'b0;
    tick();
    total++;
    if (vld !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL cont_idle_edge: got valid=%b busy=%b, want 0 0", vld, busy);
    end
    tick();
    total++;
    if ({vld, hs, vs, busy} !== 4'b1111 || hc !== 12'd0 || vc !== 12'd0) begin
      bad++;
      $display("FAIL cont_first: got v/hs/vs/busy=%b hc=%0d vc=%0d, want 1111 0 0",
               {vld, hs, vs, busy}, hc, vc);
    end
    for (int k = 1; k < 560; k++) begin
      tick();
      total++;
      if ({vld, hs, he, vs, ve, fd} !== exp_ctl(k % 20, (k / 20) % 14, 16, 12, 20, 14) ||
          hc !== 12'(k % 20) || vc !== 12'((k / 20) % 14)) begin
        bad++;
        $display("FAIL cont_slot%0d: got ctl=%b hc=%0d vc=%0d, want ctl=%b hc=%0d vc=%0d",
                 k, {vld, hs, he, vs, ve, fd}, hc, vc,
                 exp_ctl(k % 20, (k / 20) % 14, 16, 12, 20, 14), k % 20, (k / 20) % 14);
      end
      if (fd === 1'b1) begin
        if (fd_first < 0) fd_first = k; else if (fd_second < 0) fd_second = k;
      end
      if (ve === 1'b1 && ve_k < 0) ve_k = k;
      if (he === 1'b1 && k < 280) he_n++;
    end
    total++;
    if (fd_first != 279 || fd_second != 559) begin
      bad++;
      $display("FAIL cont_fd_period: got fd at %0d,%0d, want 279,559", fd_first, fd_second);
    end
    total++;
    if (ve_k != 235) begin
      bad++;
      $display("FAIL cont_vend_pos: got vEnd at slot %0d, want 235", ve_k);
    end
    total++;
    if (he_n != 12) begin
      bad++;
      $display("FAIL cont_hend_count: got %0d, want 12", he_n);
    end
  endtask

  task automatic test_stall();
    int k, last_h, last_v, fd_j;
    k = 0; last_h = 0; last_v = 0; fd_j = -1;
    reset = 1'b1; one_shot = 1'b0; valid_in = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int j = 0; j < 560; j++) begin
      valid_in = (j % 2 == 0);
      tick();
      total++;
      if (valid_in) begin
        if ({vld, hs, he, vs, ve, fd} !== exp_ctl(k % 20, (k / 20) % 14, 16, 12, 20, 14) ||
            hc !== 12'(k % 20) || vc !== 12'((k / 20) % 14) || busy !== 1'b1) begin
          bad++;
          $display("FAIL stall_step%0d: got ctl=%b hc=%0d vc=%0d busy=%b, want ctl=%b hc=%0d vc=%0d busy=1",
                   j, {vld, hs, he, vs, ve, fd}, hc, vc, busy,
                   exp_ctl(k % 20, (k / 20) % 14, 16, 12, 20, 14), k % 20, (k / 20) % 14);
        end
        last_h = k % 20; last_v = (k / 20) % 14;
        k++;
      end else begin
        if ({vld, hs, he, vs, ve, fd} !== 6'b0 || hc !== 12'(last_h) || vc !== 12'(last_v)) begin
          bad++;
          $display("FAIL stall_hold%0d: got ctl=%b hc=%0d vc=%0d, want ctl=0 hc=%0d vc=%0d",
                   j, {vld, hs, he, vs, ve, fd}, hc, vc, last_h, last_v);
        end
      end
      if (fd === 1'b1 && fd_j < 0) fd_j = j;
    end
    total++;
    if (fd_j != 558) begin
      bad++;
      $display("FAIL stall_fd_pos: got frame_done at step %0d, want 558", fd_j);
    end
    valid_in = 1'b1;
  endtask

  task automatic test_one_shot();
    reset = 1'b1; one_shot = 1'b1; valid_in = 1'b1; start = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    total++;
    if (busy !== 1'b0 || vld !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_no_autorun: got busy=%b valid=%b, want 0 0", busy, vld);
    end
    for (int rep = 0; rep < 2; rep++) begin
      int nv, nvs, nve, nfd, t_fd, busy_fd, busy_after;
      nv = 0; nvs = 0; nve = 0; nfd = 0; t_fd = -1; busy_fd = -1; busy_after = -1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 1; t <= 300; t++) begin
        start = (rep == 1) && (t == 100 || t == 280);
        tick();
        start = 1'b0;
        nv  += int'(vld === 1'b1);
        nvs += int'(vs === 1'b1);
        nve += int'(ve === 1'b1);
        if (fd === 1'b1) begin
          nfd++; t_fd = t; busy_fd = int'(busy);
        end
        if (t_fd > 0 && t == t_fd + 1) busy_after = int'(busy);
      end
      total++;
      if (nv != 192 || nvs != 1 || nve != 1 || nfd != 1) begin
        bad++;
        $display("FAIL oneshot_counts%0d: got valid=%0d vS=%0d vE=%0d fd=%0d, want 192 1 1 1",
                 rep, nv, nvs, nve, nfd);
      end
      total++;
      if (t_fd != 280 || busy_fd != 1 || busy_after != 0) begin
        bad++;
        $display("FAIL oneshot_busy%0d: got fd@%0d busy_fd=%0d busy_after=%0d, want 280 1 0",
                 rep, t_fd, busy_fd, busy_after);
      end
      total++;
      if (busy !== 1'b0 || vld !== 1'b0 || hc !== 12'd0 || vc !== 12'd0) begin
        bad++;
        $display("FAIL oneshot_idle%0d: got busy=%b valid=%b hc=%0d vc=%0d, want 0 0 0 0",
                 rep, busy, vld, hc, vc);
      end
    end
    one_shot = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    reset = 1'b1; one_shot = 1'b0; valid_in = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      if (vld === 1'b1 && hc == 12'd7 && vc == 12'd5) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL midreset_reach: got no slot (7,5) in 400 cycles, want it reached");
    end
    reset = 1'b1;
    tick();
    total++;
    if ({hs, he, vs, ve, vld, fd, busy} !== 7'b0 || hc !== 12'd0 || vc !== 12'd0) begin
      bad++;
      $display("FAIL midreset_clear: got ctl=%b hc=%0d vc=%0d, want all 0",
               {hs, he, vs, ve, vld, fd, busy}, hc, vc);
    end
    reset = 1'b0;
    tick();
    tick();
    total++;
    if ({vs, hs, vld} !== 3'b111 || hc !== 12'd0 || vc !== 12'd0) begin
      bad++;
      $display("FAIL midreset_restart: got vS/hS/valid=%b hc=%0d vc=%0d, want 111 0 0",
               {vs, hs, vld}, hc, vc);
    end
  endtask

  task automatic test_zero_blank();
    int nfd;
    nfd = 0;
    reset = 1'b1; one_shot = 1'b0; valid_in = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int k = 0; k < 24; k++) begin
      tick();
      total++;
      if ({vld2, hs2, he2, vs2, ve2, fd2} !== exp_ctl(k % 4, (k / 4) % 3, 4, 3, 4, 3) ||
          hc2 !== 12'(k % 4) || vc2 !== 12'((k / 4) % 3)) begin
        bad++;
        $display("FAIL zeroblank_slot%0d: got ctl=%b hc=%0d vc=%0d, want ctl=%b hc=%0d vc=%0d",
                 k, {vld2, hs2, he2, vs2, ve2, fd2}, hc2, vc2,
                 exp_ctl(k % 4, (k / 4) % 3, 4, 3, 4, 3), k % 4, (k / 4) % 3);
      end
      if (fd2 === 1'b1 && ve2 === 1'b1) nfd++;
    end
    total++;
    if (nfd != 2) begin
      bad++;
      $display("FAIL zeroblank_vend_fd: got %0d coincident vEnd/frame_done, want 2", nfd);
    end
  endtask

`ifdef PIXEL_CTRL_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int nfd;
    nfd = 0;
    reset = 1'b1; one_shot = 1'b0; valid_in = 1'b1;
    tick();
    total++;
    if (fc !== 16'd0) begin
      bad++;
      $display("FAIL fcnt_reset: got %0d, want 0", fc);
    end
    reset = 1'b0;
    tick();
    for (int k = 0; k < 840; k++) begin
      tick();
      if (fd === 1'b1) begin
        nfd++;
        total++;
        if (fc !== 16'(nfd)) begin
          bad++;
          $display("FAIL fcnt_at_fd%0d: got %0d, want %0d", nfd, fc, nfd);
        end
      end
    end
    total++;
    if (fc !== 16'd3 || nfd != 3) begin
      bad++;
      $display("FAIL fcnt_final: got cnt=%0d frames=%0d, want 3 3", fc, nfd);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_stall();
    test_one_shot();
    test_reset_mid();
    test_zero_blank();
`ifdef PIXEL_CTRL_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
